// File: rtl/hamming_encoder_tx_if.sv
// Word-in / serial-out link between a data source and the Hamming(15,11) transmitter.
// The source drives the word side; the transmitter drives ready and the line side.
interface hamming_encoder_tx_if;
  logic [10:0] data_in;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  inj_pos;
  logic        tx_bit;
  logic        tx_active;
  logic        tx_last;
  logic [14:0] codeword_out;

  modport master (
    output data_in, in_valid, inj_pos,
    input  in_ready, tx_bit, tx_active, tx_last, codeword_out
  );

  modport slave (
    input  data_in, in_valid, inj_pos,
    output in_ready, tx_bit, tx_active, tx_last, codeword_out
  );
endinterface

// File: rtl/hamming_encoder_tx.sv
// Hamming(15,11) encoder with LSB-first serial transmitter, one-word hold buffer
// for gapless back-to-back frames, and single-bit error injection.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | line quiet, waiting for a word; hold buffer is always empty
// S_SHIFT | frame on the line; bit_idx selects the code bit, tick times it
module hamming_encoder_tx #(
  parameter int CLKS_PER_BIT = 1
) (
  input logic               clk,
  input logic               rst_n,
  hamming_encoder_tx_if.slave link
);

  localparam int TICK_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0] LAST_IDX = 4'd14;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t            state_q, state_nxt;
  logic [14:0]       shreg_q, shreg_nxt;
  logic [14:0]       cw_q, cw_nxt;
  logic [3:0]        bit_idx_q, bit_idx_nxt;
  logic [TICK_W-1:0] tick_q, tick_nxt;
  logic              hold_full_q, hold_full_nxt;
  logic [14:0]       hold_cw_q, hold_cw_nxt;

  logic        in_ready_i;
  logic        accept;
  logic        bit_end;
  logic [14:0] cw_in;
  logic        load_en;
  logic [14:0] load_cw;

  // Code index c[i] is Hamming position i+1; parities sit at c0, c1, c3, c7.
  function automatic logic [14:0] encode(input logic [10:0] d, input logic [3:0] inj);
    logic [14:0] c;
    c        = '0;
    c[2]     = d[0];
    c[4]     = d[1];
    c[5]     = d[2];
    c[6]     = d[3];
    c[14:8]  = d[10:4];
    c[0]     = ^{c[2], c[4], c[6], c[8], c[10], c[12], c[14]};
    c[1]     = ^{c[2], c[5], c[6], c[9], c[10], c[13], c[14]};
    c[3]     = ^{c[4], c[5], c[6], c[11], c[12], c[13], c[14]};
    c[7]     = ^c[14:8];
    if (inj != 4'd0) begin
      c[inj - 4'd1] = ~c[inj - 4'd1];
    end
    return c;
  endfunction

  // Ready depends only on registered hold state and reset, never on in_valid.
  assign in_ready_i = rst_n && !hold_full_q;
  assign accept     = link.in_valid && in_ready_i;
  assign cw_in      = encode(link.data_in, link.inj_pos);
  assign bit_end    = (tick_q == TICK_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      shreg_q     <= '0;
      cw_q        <= '0;
      bit_idx_q   <= '0;
      tick_q      <= '0;
      hold_full_q <= 1'b0;
      hold_cw_q   <= '0;
    end else begin
      state_q     <= state_nxt;
      shreg_q     <= shreg_nxt;
      cw_q        <= cw_nxt;
      bit_idx_q   <= bit_idx_nxt;
      tick_q      <= tick_nxt;
      hold_full_q <= hold_full_nxt;
      hold_cw_q   <= hold_cw_nxt;
    end
  end

  always_comb begin
    state_nxt     = state_q;
    shreg_nxt     = shreg_q;
    cw_nxt        = cw_q;
    bit_idx_nxt   = bit_idx_q;
    tick_nxt      = tick_q;
    hold_full_nxt = hold_full_q;
    hold_cw_nxt   = hold_cw_q;
    load_en       = 1'b0;
    load_cw       = '0;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          load_en = 1'b1;
          load_cw = cw_in;
        end
      end
      S_SHIFT: begin
        if (accept) begin
          hold_full_nxt = 1'b1;
          hold_cw_nxt   = cw_in;
        end
        if (!bit_end) begin
          tick_nxt = tick_q + TICK_W'(1);
        end else if (bit_idx_q != LAST_IDX) begin
          tick_nxt    = '0;
          bit_idx_nxt = bit_idx_q + 4'd1;
          shreg_nxt   = {1'b0, shreg_q[14:1]};
        end else if (hold_full_q) begin
          load_en       = 1'b1;
          load_cw       = hold_cw_q;
          hold_full_nxt = 1'b0;
        end else if (accept) begin
          // Word arriving exactly on the frame boundary bypasses the hold buffer.
          load_en       = 1'b1;
          load_cw       = cw_in;
          hold_full_nxt = 1'b0;
        end else begin
          state_nxt   = S_IDLE;
          shreg_nxt   = '0;
          tick_nxt    = '0;
          bit_idx_nxt = '0;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    if (load_en) begin
      state_nxt   = S_SHIFT;
      shreg_nxt   = load_cw;
      cw_nxt      = load_cw;
      bit_idx_nxt = '0;
      tick_nxt    = '0;
    end
  end

  assign link.in_ready     = in_ready_i;
  assign link.tx_active    = (state_q == S_SHIFT);
  assign link.tx_bit       = shreg_q[0];
  assign link.tx_last      = (state_q == S_SHIFT) && (bit_idx_q == LAST_IDX);
  assign link.codeword_out = cw_q;

endmodule

// File: tb/tb_hamming_encoder_tx.sv
// Scoreboard bench for hamming_encoder_tx: one instance at 1 clock/bit, one at 3.
// Frames are rebuilt from the serial line and checked against a syndrome-based model.
module tb_hamming_encoder_tx;

  logic clk;
  logic rst_n;

  hamming_encoder_tx_if if_a ();
  hamming_encoder_tx_if if_b ();

  hamming_encoder_tx #(.CLKS_PER_BIT(1)) dut_a (.clk(clk), .rst_n(rst_n), .link(if_a));
  hamming_encoder_tx #(.CLKS_PER_BIT(3)) dut_b (.clk(clk), .rst_n(rst_n), .link(if_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [14:0] cw;
    logic [10:0] data;
    logic [3:0]  inj;
  } sb_t;

  sb_t q0[$];
  sb_t q1[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] syndrome(input logic [14:0] c);
    logic [3:0] s;
    s = 4'd0;
    for (int i = 0; i < 15; i++) begin
      if (c[i]) s = s ^ 4'(i + 1);
    end
    return s;
  endfunction

  // Parity bits chosen so the position-XOR syndrome of the word is zero.
  function automatic logic [14:0] model_encode(input logic [10:0] d, input logic [3:0] inj);
    logic [14:0] c;
    logic [3:0]  s;
    c       = '0;
    c[2]    = d[0];
    c[4]    = d[1];
    c[5]    = d[2];
    c[6]    = d[3];
    c[14:8] = d[10:4];
    s       = syndrome(c);
    c[0]    = s[0];
    c[1]    = s[1];
    c[3]    = s[2];
    c[7]    = s[3];
    if (inj != 4'd0) c[inj - 4'd1] = ~c[inj - 4'd1];
    return c;
  endfunction

  function automatic logic [10:0] decode(input logic [14:0] cw);
    logic [14:0] c;
    logic [3:0]  s;
    c = cw;
    s = syndrome(c);
    if (s != 4'd0) c[s - 4'd1] = ~c[s - 4'd1];
    return {c[14:8], c[6], c[5], c[4], c[2]};
  endfunction

  // ---------------- line monitor ----------------
  int          mcnt[2];
  int          mlast[2];
  int          mrun[2];
  int          last_run[2];
  logic [14:0] mbits[2];
  logic [14:0] mcwo[2];
  logic        mbad[2];

  task automatic mon_step(input int k, input logic b, input logic act, input logic lst,
                          input logic [14:0] cwo);
    int  cpb;
    int  p;
    int  sz;
    sb_t e;
    cpb = (k == 0) ? 1 : 3;
    if (act) begin
      mrun[k]++;
      if (mcnt[k] == 0) begin
        mcwo[k]  = cwo;
        mbits[k] = '0;
        mlast[k] = 0;
        mbad[k]  = 1'b0;
      end
      p = mcnt[k] / cpb;
      if (mcnt[k] % cpb == 0) mbits[k][p] = b;
      else if (mbits[k][p] !== b) mbad[k] = 1'b1;
      if (lst !== (p == 14)) mbad[k] = 1'b1;
      if (lst) mlast[k]++;
      if (cwo !== mcwo[k]) mbad[k] = 1'b1;
      mcnt[k]++;
      if (mcnt[k] == 15 * cpb) begin
        mcnt[k] = 0;
        sz = (k == 0) ? q0.size() : q1.size();
        if (sz == 0) begin
          check_eq("sb_underflow", 32'd1, 32'd0);
        end else begin
          if (k == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          check_eq("codeword_out", 32'(mcwo[k]), 32'(e.cw));
          check_eq("serial_cw", 32'(mbits[k]), 32'(e.cw));
          check_eq("decoded", 32'(decode(mbits[k])), 32'(e.data));
          if (e.inj == 4'd0) check_eq("syndrome", 32'(syndrome(mbits[k])), 32'd0);
          check_eq("tx_last_cycles", 32'(mlast[k]), 32'(cpb));
          check_eq("bit_timing", 32'(mbad[k]), 32'd0);
        end
      end
    end else begin
      if (mrun[k] != 0) last_run[k] = mrun[k];
      mrun[k] = 0;
      if (mcnt[k] != 0) begin
        check_eq("frame_trunc", 32'(mcnt[k]), 32'd0);
        mcnt[k] = 0;
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      for (int i = 0; i < 2; i++) begin
        mcnt[i] = 0;
        mrun[i] = 0;
      end
    end else begin
      mon_step(0, if_a.tx_bit, if_a.tx_active, if_a.tx_last, if_a.codeword_out);
      mon_step(1, if_b.tx_bit, if_b.tx_active, if_b.tx_last, if_b.codeword_out);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input int k, input logic v, input logic [10:0] d, input logic [3:0] inj);
    if (k == 0) begin
      if_a.in_valid = v; if_a.data_in = d; if_a.inj_pos = inj;
    end else begin
      if_b.in_valid = v; if_b.data_in = d; if_b.inj_pos = inj;
    end
  endtask

  function automatic logic ready_of(input int k);
    return (k == 0) ? if_a.in_ready : if_b.in_ready;
  endfunction

  function automatic logic active_of(input int k);
    return (k == 0) ? if_a.tx_active : if_b.tx_active;
  endfunction

  // Called just after a rising edge; in_ready is registered so it predicts the next edge.
  task automatic send(input int k, input logic [10:0] d, input logic [3:0] inj,
                      input logic [14:0] exp_cw, input bit use_model, output int waits);
    sb_t e;
    waits = 0;
    drive(k, 1'b1, d, inj);
    while (!ready_of(k) && waits < 200) begin
      @(posedge clk); #1;
      waits++;
    end
    if (!ready_of(k)) begin
      check_eq("accept_timeout", 32'd0, 32'd1);
      drive(k, 1'b0, 11'd0, 4'd0);
    end else begin
      e.cw   = use_model ? model_encode(d, inj) : exp_cw;
      e.data = d;
      e.inj  = inj;
      if (k == 0) q0.push_back(e);
      else        q1.push_back(e);
      @(posedge clk); #1;
      drive(k, 1'b0, ~d, inj + 4'd5);
    end
  endtask

  task automatic wait_idle(input int k);
    int n;
    int sz;
    n  = 0;
    sz = (k == 0) ? q0.size() : q1.size();
    while ((active_of(k) || sz != 0) && n < 3000) begin
      @(posedge clk); #1;
      n++;
      sz = (k == 0) ? q0.size() : q1.size();
    end
    check_eq("drain", 32'(sz), 32'd0);
    @(negedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int act_seen;
    logic [10:0] rd;

    rst_n = 1'b0;
    drive(0, 1'b0, 11'd0, 4'd0);
    drive(1, 1'b0, 11'd0, 4'd0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_a_active", 32'(if_a.tx_active), 32'd0);
    check_eq("rst_a_bit", 32'(if_a.tx_bit), 32'd0);
    check_eq("rst_a_last", 32'(if_a.tx_last), 32'd0);
    check_eq("rst_a_cw", 32'(if_a.codeword_out), 32'd0);
    check_eq("rst_a_ready", 32'(if_a.in_ready), 32'd0);
    check_eq("rst_b_active", 32'(if_b.tx_active), 32'd0);
    check_eq("rst_b_ready", 32'(if_b.in_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    check_eq("ready_after_rst", 32'(if_a.in_ready), 32'd1);
    @(posedge clk); #1;

    // Directed codewords.
    send(0, 11'h000, 4'd0, 15'h0000, 1'b0, w);
    wait_idle(0);
    check_eq("frame_len_1", 32'(last_run[0]), 32'd15);
    send(0, 11'h001, 4'd0, 15'h0007, 1'b0, w);
    wait_idle(0);
    send(0, 11'h400, 4'd0, 15'h408B, 1'b0, w);
    wait_idle(0);
    send(0, 11'h7FF, 4'd0, 15'h7FFF, 1'b0, w);
    wait_idle(0);
    send(0, 11'h001, 4'd3, 15'h0003, 1'b0, w);
    wait_idle(0);

    // Three back-to-back words: second lands mid-frame, third waits on the hold buffer.
    send(0, 11'h2A5, 4'd0, 15'h0, 1'b1, w);
    repeat (4) begin @(posedge clk); #1; end
    send(0, 11'h15A, 4'd0, 15'h0, 1'b1, w);
    check_eq("hold_accept_waits", 32'(w), 32'd0);
    send(0, 11'h6C3, 4'd0, 15'h0, 1'b1, w);
    check_eq("ready_low_cycles", 32'(w), 32'd10);
    wait_idle(0);
    check_eq("b2b_active_len", 32'(last_run[0]), 32'd45);

    // Random clean words streamed, then random single-bit injections.
    for (int i = 0; i < 64; i++) begin
      rd = 11'($urandom);
      send(0, rd, 4'd0, 15'h0, 1'b1, w);
    end
    for (int i = 0; i < 16; i++) begin
      rd = 11'($urandom);
      send(0, rd, 4'($urandom_range(1, 15)), 15'h0, 1'b1, w);
    end
    wait_idle(0);

    // Three clocks per bit.
    send(1, 11'h001, 4'd0, 15'h0007, 1'b0, w);
    wait_idle(1);
    check_eq("cpb3_frame_len", 32'(last_run[1]), 32'd45);
    send(1, 11'h3C5, 4'd0, 15'h0, 1'b1, w);
    send(1, 11'h05A, 4'd9, 15'h0, 1'b1, w);
    wait_idle(1);
    check_eq("cpb3_b2b_len", 32'(last_run[1]), 32'd90);

    // Reset at bit index 7 with the hold buffer full.
    send(0, 11'h1F0, 4'd0, 15'h0, 1'b1, w);
    send(0, 11'h00F, 4'd0, 15'h0, 1'b1, w);
    repeat (6) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_eq("midrst_active", 32'(if_a.tx_active), 32'd0);
    check_eq("midrst_bit", 32'(if_a.tx_bit), 32'd0);
    check_eq("midrst_last", 32'(if_a.tx_last), 32'd0);
    check_eq("midrst_cw", 32'(if_a.codeword_out), 32'd0);
    check_eq("midrst_ready", 32'(if_a.in_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    check_eq("midrst_ready_rel", 32'(if_a.in_ready), 32'd1);
    act_seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (if_a.tx_active) act_seen = 1;
    end
    check_eq("no_resume", 32'(act_seen), 32'd0);

    send(0, 11'h555, 4'd0, 15'h0, 1'b1, w);
    wait_idle(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
